// File: rtl/key_expansion_sched_if.sv
// Bus bundle between the AES-256 key scheduler, its SubWord unit and the round datapath.
// KEYEXP_RK_STORE_EN adds the round-key store read port.
interface key_expansion_sched_if;
   logic         start;
   logic [255:0] key_in;
   logic [31:0]  subword_in;
   logic [31:0]  subword_out;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         done;
`ifdef KEYEXP_RK_STORE_EN
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;

   modport slave  (input  start, key_in, subword_out, rk_rd_idx,
                   output subword_in, busy, rk_valid, rk_idx, rk_data, done, rk_rd_data);
   modport master (output start, key_in, subword_out, rk_rd_idx,
                   input  subword_in, busy, rk_valid, rk_idx, rk_data, done, rk_rd_data);
`else
   modport slave  (input  start, key_in, subword_out,
                   output subword_in, busy, rk_valid, rk_idx, rk_data, done);
   modport master (output start, key_in, subword_out,
                   input  subword_in, busy, rk_valid, rk_idx, rk_data, done);
`endif
endinterface

// File: rtl/key_expansion_sched.sv
// Sequential AES-256 key schedule: 8-word sliding window, one word per step, external SubWord.
// Optional round-key store enabled by defining KEYEXP_RK_STORE_EN.
module key_expansion_sched #(
   parameter int SUB_LATENCY = 1
) (
   input logic                    sys_clk,
   input logic                    sys_rst_n,
   key_expansion_sched_if.slave   io_kx
);
   typedef enum logic [2:0] {ST_IDLE, ST_KEY0, ST_KEY1, ST_GEN, ST_SUB_WAIT, ST_FIN} state_t;
   localparam logic [1:0] SUB_LAST = 2'(SUB_LATENCY - 1);

   state_t       r_state;
   logic [31:0]  r_win [8];   // r_win[0] = w[i-8] ... r_win[7] = w[i-1]
   logic [5:0]   r_i;
   logic [1:0]   r_cnt;
   logic [31:0]  r_sub_in;
   logic         r_busy;
   logic         r_rk_valid;
   logic [3:0]   r_rk_idx;
   logic [127:0] r_rk_data;
   logic         r_done;

   logic [7:0]   w_rcon;
   logic [31:0]  w_sub_x;
   logic [31:0]  w_new;
   logic         w_wr;

   always_comb begin
      w_rcon = 8'h00;
      case (r_i[5:3])
         3'd1: w_rcon = 8'h01;
         3'd2: w_rcon = 8'h02;
         3'd3: w_rcon = 8'h04;
         3'd4: w_rcon = 8'h08;
         3'd5: w_rcon = 8'h10;
         3'd6: w_rcon = 8'h20;
         3'd7: w_rcon = 8'h40;
         default: w_rcon = 8'h00;
      endcase
   end

   // i%8==0 folds in Rcon; i%8==4 is the plain SubWord step
   assign w_sub_x = r_win[0] ^ io_kx.subword_out ^ (r_i[2] ? 32'h0 : {w_rcon, 24'h0});

   always_comb begin
      w_wr  = 1'b0;
      w_new = r_win[0] ^ r_win[7];
      if (r_state == ST_GEN && r_i[1:0] != 2'd0) begin
         w_wr = 1'b1;
      end else if (r_state == ST_SUB_WAIT && r_cnt == SUB_LAST) begin
         w_wr  = 1'b1;
         w_new = w_sub_x;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= ST_IDLE;
         for (int k = 0; k < 8; k++) r_win[k] <= '0;
         r_i        <= '0;
         r_cnt      <= '0;
         r_sub_in   <= '0;
         r_busy     <= 1'b0;
         r_rk_valid <= 1'b0;
         r_rk_idx   <= '0;
         r_rk_data  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_rk_valid <= 1'b0;
         r_done     <= 1'b0;
         if (w_wr) begin
            for (int k = 0; k < 7; k++) r_win[k] <= r_win[k+1];
            r_win[7] <= w_new;
            r_i      <= r_i + 6'd1;
            if (r_i[1:0] == 2'd3) begin
               r_rk_valid <= 1'b1;
               r_rk_idx   <= r_i[5:2];
               r_rk_data  <= {r_win[5], r_win[6], r_win[7], w_new};
            end
         end
         case (r_state)
            ST_IDLE: begin
               if (io_kx.start) begin
                  for (int k = 0; k < 8; k++) r_win[k] <= io_kx.key_in[255-32*k -: 32];
                  r_i        <= 6'd8;
                  r_busy     <= 1'b1;
                  r_rk_valid <= 1'b1;
                  r_rk_idx   <= 4'd0;
                  r_rk_data  <= io_kx.key_in[255:128];
                  r_state    <= ST_KEY0;
               end
            end
            ST_KEY0: begin
               r_rk_valid <= 1'b1;
               r_rk_idx   <= 4'd1;
               r_rk_data  <= {r_win[4], r_win[5], r_win[6], r_win[7]};
               r_state    <= ST_KEY1;
            end
            // w8 needs SubWord, so its RotWord is launched straight from KEY1
            ST_KEY1: begin
               r_sub_in <= {r_win[7][23:0], r_win[7][31:24]};
               r_cnt    <= '0;
               r_state  <= ST_SUB_WAIT;
            end
            ST_GEN: begin
               if (r_i[1:0] == 2'd0) begin
                  r_sub_in <= r_i[2] ? r_win[7] : {r_win[7][23:0], r_win[7][31:24]};
                  r_cnt    <= '0;
                  r_state  <= ST_SUB_WAIT;
               end else if (r_i == 6'd59) begin
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end
            end
            ST_SUB_WAIT: begin
               if (r_cnt == SUB_LAST) r_state <= ST_GEN;
               else                   r_cnt   <= r_cnt + 2'd1;
            end
            ST_FIN: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign io_kx.subword_in = r_sub_in;
   assign io_kx.busy       = r_busy;
   assign io_kx.rk_valid   = r_rk_valid;
   assign io_kx.rk_idx     = r_rk_idx;
   assign io_kx.rk_data    = r_rk_data;
   assign io_kx.done       = r_done;

`ifdef KEYEXP_RK_STORE_EN
   logic [127:0] r_store [15];
   logic [127:0] r_rd_data;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int k = 0; k < 15; k++) r_store[k] <= '0;
         r_rd_data <= '0;
      end else begin
         if (r_rk_valid && r_rk_idx <= 4'd14) r_store[r_rk_idx] <= r_rk_data;
         r_rd_data <= (io_kx.rk_rd_idx > 4'd14) ? 128'h0 : r_store[io_kx.rk_rd_idx];
      end
   end

   assign io_kx.rk_rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_key_expansion_sched.sv
// Directed bench: FIPS-197 A.3 AES-256 key on SUB_LATENCY=1 and SUB_LATENCY=3 instances.
// Both share start/key/reset; SubWord is modelled as S-box plus SUB_LATENCY-1 register stages.
module tb_key_expansion_sched;
   localparam logic [255:0] K1 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

   logic         sys_clk = 1'b0;
   logic         sys_rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] key = '0;
   logic [31:0]  a_sub, b_d1, b_d2;
   int n_chk = 0, n_err = 0;

   key_expansion_sched_if ifa ();
   key_expansion_sched_if ifb ();

   key_expansion_sched #(.SUB_LATENCY(1)) dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .io_kx(ifa));
   key_expansion_sched #(.SUB_LATENCY(3)) dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .io_kx(ifb));

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] sb(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   always_comb a_sub = sb(ifa.subword_in);
   always @(posedge sys_clk) begin
      b_d1 <= sb(ifb.subword_in);
      b_d2 <= b_d1;
   end

   assign ifa.start = start;
   assign ifb.start = start;
   assign ifa.key_in = key;
   assign ifb.key_in = key;
   assign ifa.subword_out = a_sub;
   assign ifb.subword_out = b_d2;
`ifdef KEYEXP_RK_STORE_EN
   logic [3:0] rd_idx = '0;
   assign ifa.rk_rd_idx = rd_idx;
   assign ifb.rk_rd_idx = rd_idx;
`endif

   logic [127:0] exp_rk [15];
   logic [127:0] a_rk [32], b_rk [32];
   logic [3:0]   a_idx [32];
   int a_n, b_n, a_busy, b_busy, a_first, a_done_n, a_done14, b_done_n, run_to;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference schedule written directly from the word-recurrence definition
   task automatic expand_key(input logic [255:0] k);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int j = 0; j < 8; j++) w[j] = k[255-32*j -: 32];
      for (int j = 8; j < 60; j++) begin
         t = w[j-1];
         if (j % 8 == 0) begin
            t  = sb({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = rc << 1;
         end else if (j % 8 == 4) begin
            t = sb(t);
         end
         w[j] = w[j-8] ^ t;
      end
      for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Starts a run with K1; optionally re-pulses start with K2 or asserts reset at a given cycle
   task automatic run(input int restart_at, input int abort_at);
      a_n = 0; b_n = 0; a_busy = 0; b_busy = 0; a_first = 0;
      a_done_n = 0; a_done14 = 0; b_done_n = 0; run_to = 1;
      @(negedge sys_clk);
      start = 1'b1;
      key   = K1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge sys_clk);
         start = (c == restart_at);
         key   = (c == restart_at) ? K2 : ~K1;
         if (ifa.busy) a_busy++;
         if (ifb.busy) b_busy++;
         if (ifa.rk_valid && a_n < 32) begin
            if (a_n == 0) a_first = c;
            a_rk[a_n] = ifa.rk_data; a_idx[a_n] = ifa.rk_idx; a_n++;
         end
         if (ifb.rk_valid && b_n < 32) begin
            b_rk[b_n] = ifb.rk_data; b_n++;
         end
         if (ifa.done) begin
            a_done_n++;
            if (ifa.rk_valid && ifa.rk_idx == 4'd14) a_done14++;
         end
         if (ifb.done) b_done_n++;
         if (c == abort_at) begin
            sys_rst_n = 1'b0;
            run_to = 0;
            break;
         end
         if (c > 2 && !ifa.busy && !ifb.busy) begin
            run_to = 0;
            break;
         end
      end
   endtask

   task automatic check_full_run(input string tag, input int exp_b_busy);
      chk({tag, "_timeout"}, 128'(run_to), 128'd0);
      chk({tag, "_a_pulses"}, 128'(a_n), 128'd15);
      chk({tag, "_b_pulses"}, 128'(b_n), 128'd15);
      chk({tag, "_a_first"}, 128'(a_first), 128'd1);
      chk({tag, "_a_busy"}, 128'(a_busy), 128'd67);
      chk({tag, "_b_busy"}, 128'(b_busy), 128'(exp_b_busy));
      chk({tag, "_a_done"}, 128'(a_done_n), 128'd1);
      chk({tag, "_a_done_rk14"}, 128'(a_done14), 128'd1);
      chk({tag, "_b_done"}, 128'(b_done_n), 128'd1);
      for (int k = 0; k < 15; k++) begin
         chk($sformatf("%s_a_idx%0d", tag, k), 128'(a_idx[k]), 128'(k));
         chk($sformatf("%s_a_rk%0d", tag, k), a_rk[k], exp_rk[k]);
         chk($sformatf("%s_b_rk%0d", tag, k), b_rk[k], exp_rk[k]);
      end
      chk({tag, "_rk2_fips"}, a_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
      chk({tag, "_rk14_fips"}, a_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
   endtask

   initial begin
      expand_key(K1);
      repeat (3) @(negedge sys_clk);
      chk("rst_busy", 128'(ifa.busy), 128'd0);
      chk("rst_rk_valid", 128'(ifa.rk_valid), 128'd0);
      chk("rst_done", 128'(ifa.done), 128'd0);
      chk("rst_rk_idx", 128'(ifa.rk_idx), 128'd0);
      chk("rst_rk_data", ifa.rk_data, 128'd0);
      chk("rst_subword_in", 128'(ifa.subword_in), 128'd0);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      chk("idle_rk_valid", 128'(ifa.rk_valid), 128'd0);

      run(0, 0);
      check_full_run("run1", 93);

      run(20, 0);
      check_full_run("restart", 93);
      repeat (3) @(negedge sys_clk);
      chk("restart_no_rerun", 128'(ifa.busy | ifb.busy), 128'd0);

      run(0, 30);
      #1;
      chk("abort_busy", 128'({ifa.busy, ifb.busy}), 128'd0);
      chk("abort_rk_valid", 128'({ifa.rk_valid, ifb.rk_valid}), 128'd0);
      chk("abort_done", 128'({ifa.done, ifb.done}), 128'd0);
      chk("abort_rk_data", ifa.rk_data, 128'd0);
      chk("abort_rk_idx", 128'(ifa.rk_idx), 128'd0);
      chk("abort_subword_in", 128'(ifa.subword_in), 128'd0);
      chk("abort_a_done_seen", 128'(a_done_n), 128'd0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      a_n = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge sys_clk);
         if (ifa.rk_valid || ifa.done || ifb.rk_valid || ifb.done) a_n++;
      end
      chk("abort_no_late_pulse", 128'(a_n), 128'd0);

      run(0, 0);
      check_full_run("post_reset", 93);

`ifdef KEYEXP_RK_STORE_EN
      @(negedge sys_clk);
      rd_idx = 4'd0;
      @(negedge sys_clk);
      chk("store_rd0", ifa.rk_rd_data, K1[255:128]);
      rd_idx = 4'd14;
      @(negedge sys_clk);
      chk("store_rd14", ifa.rk_rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
      rd_idx = 4'd15;
      @(negedge sys_clk);
      chk("store_rd15", ifa.rk_rd_data, 128'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
